// File: rtl/sfx_tone_mixer.sv
// sfx_tone_mixer
// Multi-channel square-wave sound-effect generator and mixer. Each channel is
// a one-shot tone with a programmable half-period and duration. Channel tones
// are summed, registered, added to the microphone passthrough and saturated
// to 32-bit signed samples for the codec FIFO.
//
// Configuration macro:
//   SFX_PRIORITY_EN - when defined, only the lowest-index playing channel is
//                     heard; the others keep running but are muted.
//
// Ports:
//   clk                      system clock (50 MHz)
//   resetn                   asynchronous active-low reset
//   trig[NUM_CH]             single-cycle start pulse per channel
//   half_period              per-channel half-period, channel i at [i*HALF_W +: HALF_W]
//   duration                 per-channel play length, channel i at [i*DUR_W +: DUR_W]
//   audio_in_available       codec input FIFO has a sample
//   audio_out_allowed        codec output FIFO has space
//   left/right_channel_audio_in   microphone samples
//   read_audio_in            pop input FIFO
//   write_audio_out          push output FIFO
//   left/right_channel_audio_out  mixed, saturated samples
//   active[NUM_CH]           channel i currently playing
module sfx_tone_mixer #(
    parameter int                 NUM_CH = 4,
    parameter int                 HALF_W = 19,
    parameter int                 DUR_W  = 24,
    parameter logic signed [31:0] AMP    = 32'sd10000000
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_CH-1:0]          trig,
    input  logic [NUM_CH*HALF_W-1:0]   half_period,
    input  logic [NUM_CH*DUR_W-1:0]    duration,
    input  logic                       audio_in_available,
    input  logic                       audio_out_allowed,
    input  logic [31:0]                left_channel_audio_in,
    input  logic [31:0]                right_channel_audio_in,
    output logic                       read_audio_in,
    output logic                       write_audio_out,
    output logic [31:0]                left_channel_audio_out,
    output logic [31:0]                right_channel_audio_out,
    output logic [NUM_CH-1:0]          active
);

`ifdef SFX_PRIORITY_EN
    // Only one channel is ever summed, so one guard bit is enough.
    localparam int SUM_W = 33;
`else
    localparam int SUM_W = 32 + $clog2(NUM_CH) + 1;
`endif
    // One extra bit so mic + mix can never wrap before saturation.
    localparam int OUT_W = SUM_W + 1;

    localparam logic signed [SUM_W-1:0] AMP_EXT = {{(SUM_W-32){AMP[31]}}, AMP};

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } ch_state_t;

    ch_state_t                state_q [NUM_CH];
    logic [HALF_W-1:0]        hp_q    [NUM_CH];
    logic [HALF_W-1:0]        phase_q [NUM_CH];
    logic [DUR_W-1:0]         dur_q   [NUM_CH];
    logic [NUM_CH-1:0]        snd_q;
    logic signed [SUM_W-1:0]  contrib [NUM_CH];
    logic signed [SUM_W-1:0]  mix_next;
    logic signed [SUM_W-1:0]  mix_q;
    logic signed [OUT_W-1:0]  left_sum;
    logic signed [OUT_W-1:0]  right_sum;

    // Clamp a wide signed sum into the 32-bit signed range: it fits only when
    // every bit above bit 31 matches the sign bit.
    function automatic logic [31:0] sat32(input logic signed [OUT_W-1:0] v);
        if (v[OUT_W-1:31] == {(OUT_W-31){v[OUT_W-1]}})
            return v[31:0];
        else if (v[OUT_W-1])
            return 32'h8000_0000;
        else
            return 32'h7FFF_FFFF;
    endfunction

    // Channel FSMs. A trigger always wins over the running count: a valid one
    // (re)starts the tone at +AMP, an invalid one (zero field) silences it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                hp_q[i]    <= '0;
                phase_q[i] <= '0;
                dur_q[i]   <= '0;
            end
            snd_q <= '0;
            mix_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (trig[i]) begin
                    if ((half_period[i*HALF_W +: HALF_W] != '0) &&
                        (duration[i*DUR_W +: DUR_W] != '0)) begin
                        state_q[i] <= PLAY;
                        hp_q[i]    <= half_period[i*HALF_W +: HALF_W];
                        dur_q[i]   <= duration[i*DUR_W +: DUR_W];
                        phase_q[i] <= '0;
                        snd_q[i]   <= 1'b1;
                    end else begin
                        state_q[i] <= IDLE;
                        snd_q[i]   <= 1'b0;
                    end
                end else if (state_q[i] == PLAY) begin
                    // Leaving on dur==1 gives exactly dur cycles in PLAY.
                    dur_q[i] <= dur_q[i] - DUR_W'(1);
                    if (dur_q[i] == DUR_W'(1))
                        state_q[i] <= IDLE;
                    if (phase_q[i] == hp_q[i] - HALF_W'(1)) begin
                        phase_q[i] <= '0;
                        snd_q[i]   <= ~snd_q[i];
                    end else begin
                        phase_q[i] <= phase_q[i] + HALF_W'(1);
                    end
                end
            end
            mix_q <= mix_next;
        end
    end

    // Per-channel square-wave contribution, zero when idle.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            contrib[i] = '0;
            active[i]  = (state_q[i] == PLAY);
            if (state_q[i] == PLAY)
                contrib[i] = snd_q[i] ? AMP_EXT : -AMP_EXT;
        end
    end

    // Mixer. In priority mode the descending scan leaves the lowest-index
    // playing channel as the last assignment.
    always_comb begin
        mix_next = '0;
`ifdef SFX_PRIORITY_EN
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (state_q[i] == PLAY)
                mix_next = contrib[i];
        end
`else
        for (int i = 0; i < NUM_CH; i++)
            mix_next = mix_next + contrib[i];
`endif
    end

    // Output stage: registered mix added to the live mic samples.
    always_comb begin
        left_sum  = {{(OUT_W-32){left_channel_audio_in[31]}}, left_channel_audio_in}
                  + {mix_q[SUM_W-1], mix_q};
        right_sum = {{(OUT_W-32){right_channel_audio_in[31]}}, right_channel_audio_in}
                  + {mix_q[SUM_W-1], mix_q};
        left_channel_audio_out  = sat32(left_sum);
        right_channel_audio_out = sat32(right_sum);
    end

    assign read_audio_in   = audio_in_available & audio_out_allowed;
    assign write_audio_out = audio_in_available & audio_out_allowed;

endmodule

// File: tb/tb_sfx_tone_mixer.sv
// tb_sfx_tone_mixer
// Directed self-checking bench for sfx_tone_mixer with the default parameters
// (4 channels, HALF_W=19, DUR_W=24, AMP=10000000). Expected samples come from
// a small tone formula: a tone latched so that it is PLAYing after edge
// "start" contributes +AMP/-AMP alternating every hp cycles for dur cycles,
// and the mixed output lags the contribution by one cycle.
module tb_sfx_tone_mixer;

    localparam int                 NUM_CH = 4;
    localparam int                 HALF_W = 19;
    localparam int                 DUR_W  = 24;
    localparam logic signed [31:0] AMP    = 32'sd10000000;
`ifdef SFX_PRIORITY_EN
    localparam int MIX_MULT = 1;
`else
    localparam int MIX_MULT = 2;
`endif

    logic                     clk;
    logic                     resetn;
    logic [NUM_CH-1:0]        trig;
    logic [NUM_CH*HALF_W-1:0] half_period;
    logic [NUM_CH*DUR_W-1:0]  duration;
    logic                     audio_in_available;
    logic                     audio_out_allowed;
    logic [31:0]              left_channel_audio_in;
    logic [31:0]              right_channel_audio_in;
    logic                     read_audio_in;
    logic                     write_audio_out;
    logic [31:0]              left_channel_audio_out;
    logic [31:0]              right_channel_audio_out;
    logic [NUM_CH-1:0]        active;

    int checks   = 0;
    int failures = 0;

    sfx_tone_mixer #(
        .NUM_CH(NUM_CH),
        .HALF_W(HALF_W),
        .DUR_W (DUR_W),
        .AMP   (AMP)
    ) dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .trig                   (trig),
        .half_period            (half_period),
        .duration               (duration),
        .audio_in_available     (audio_in_available),
        .audio_out_allowed      (audio_out_allowed),
        .left_channel_audio_in  (left_channel_audio_in),
        .right_channel_audio_in (right_channel_audio_in),
        .read_audio_in          (read_audio_in),
        .write_audio_out        (write_audio_out),
        .left_channel_audio_out (left_channel_audio_out),
        .right_channel_audio_out(right_channel_audio_out),
        .active                 (active)
    );

    // 50 MHz-style clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load one channel's fields and raise its trigger bit (other bits kept).
    task automatic applyStimulus(input int ch, input int hp, input int dur);
        half_period[ch*HALF_W +: HALF_W] = HALF_W'(hp);
        duration[ch*DUR_W +: DUR_W]      = DUR_W'(dur);
        trig[ch]                         = 1'b1;
    endtask

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Contribution after edge n of a tone that is PLAYing from edge 'start'.
    function automatic logic signed [31:0] tone(input int n, input int start,
                                                input int hp, input int dur);
        if (n >= start && n < start + dur)
            return (((n - start) / hp) % 2 == 0) ? AMP : -AMP;
        return 32'sd0;
    endfunction

    // Retrigger scenario: first tone from edge 1, replaced at edge 11.
    function automatic logic signed [31:0] retrig_tone(input int n);
        if (n < 11)
            return tone(n, 1, 3, 100);
        return tone(n, 11, 5, 8);
    endfunction

    logic signed [31:0] e_now;
    logic signed [31:0] e_prev;
    logic [1:0]         hs_tbl [8];

    initial begin
        hs_tbl = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00};

        resetn                 = 1'b0;
        trig                   = '0;
        half_period            = '0;
        duration               = '0;
        audio_in_available     = 1'b1;
        audio_out_allowed      = 1'b1;
        left_channel_audio_in  = 32'h0000_1234;
        right_channel_audio_in = 32'h0000_5678;

        // Reset hold: mic passes straight through, handshake still live.
        repeat (5) tick();
        checkOutput("rst_active", {28'b0, active}, 32'h0);
        checkOutput("rst_left",   left_channel_audio_out,  32'h0000_1234);
        checkOutput("rst_right",  right_channel_audio_out, 32'h0000_5678);
        checkOutput("rst_read",   {31'b0, read_audio_in},   32'h1);
        checkOutput("rst_write",  {31'b0, write_audio_out}, 32'h1);
        resetn = 1'b1;
        tick();

        // Single tone on channel 0: hp=4, dur=20; right mic adds an offset.
        left_channel_audio_in  = 32'h0;
        right_channel_audio_in = 32'h0000_1234;
        applyStimulus(0, 4, 20);
        tick();
        trig = '0;
        for (int n = 1; n <= 23; n++) begin
            e_now  = tone(n, 1, 4, 20);
            e_prev = tone(n - 1, 1, 4, 20);
            checkOutput($sformatf("tone_active_n%0d", n), {31'b0, active[0]},
                        {31'b0, (e_now != 0)});
            checkOutput($sformatf("tone_left_n%0d", n), left_channel_audio_out, e_prev);
            checkOutput($sformatf("tone_right_n%0d", n), right_channel_audio_out,
                        32'h0000_1234 + e_prev);
            tick();
        end

        // Retrigger on channel 1: hp=3 dur=100, then hp=5 dur=8 at n=10.
        right_channel_audio_in = 32'h0;
        applyStimulus(1, 3, 100);
        tick();
        trig = '0;
        for (int n = 1; n <= 20; n++) begin
            e_now  = retrig_tone(n);
            e_prev = (n == 1) ? 32'sd0 : retrig_tone(n - 1);
            checkOutput($sformatf("retrig_active_n%0d", n), {31'b0, active[1]},
                        {31'b0, (e_now != 0)});
            checkOutput($sformatf("retrig_left_n%0d", n), left_channel_audio_out, e_prev);
            if (n == 10)
                applyStimulus(1, 5, 8);
            else
                trig = '0;
            tick();
        end
        repeat (3) tick();

        // Invalid triggers on channel 2: zero half-period, then zero duration.
        applyStimulus(2, 0, 50);
        tick();
        trig = '0;
        checkOutput("inv_hp_active", {28'b0, active}, 32'h0);
        tick();
        checkOutput("inv_hp_left", left_channel_audio_out, 32'h0);
        applyStimulus(2, 10, 0);
        tick();
        trig = '0;
        checkOutput("inv_dur_active", {28'b0, active}, 32'h0);
        tick();
        checkOutput("inv_dur_left", left_channel_audio_out, 32'h0);

        // Shortest legal tone: hp=1, dur=1 on channel 3.
        applyStimulus(3, 1, 1);
        tick();
        trig = '0;
        checkOutput("dur1_active_on", {28'b0, active}, 32'h8);
        checkOutput("dur1_left_lag",  left_channel_audio_out, 32'h0);
        tick();
        checkOutput("dur1_active_off", {28'b0, active}, 32'h0);
        checkOutput("dur1_left_amp",   left_channel_audio_out, AMP);
        tick();
        checkOutput("dur1_left_done",  left_channel_audio_out, 32'h0);

        // Saturation: channels 0 and 1 together, hp=4 so n=2 is +, n=6 is -.
        left_channel_audio_in = 32'h7FFF_FF00;
        applyStimulus(0, 4, 50);
        applyStimulus(1, 4, 50);
        tick();
        trig = '0;
        tick();
        checkOutput("sat_pos_left",  left_channel_audio_out,  32'h7FFF_FFFF);
        checkOutput("sat_pos_right", right_channel_audio_out, MIX_MULT * AMP);
        repeat (4) tick();
        left_channel_audio_in = 32'h8000_0010;
        #1;
        checkOutput("sat_neg_left",  left_channel_audio_out,  32'h8000_0000);
        checkOutput("sat_neg_right", right_channel_audio_out, -(MIX_MULT * AMP));
        repeat (50) tick();
        left_channel_audio_in = 32'h0;
        #1;
        checkOutput("sat_idle_left", left_channel_audio_out, 32'h0);

        // Channels 0 and 3 playing together.
        applyStimulus(0, 8, 10);
        applyStimulus(3, 8, 10);
        tick();
        trig = '0;
        checkOutput("pri_active", {28'b0, active}, 32'h9);
        tick();
        checkOutput("pri_left", left_channel_audio_out, MIX_MULT * AMP);
        repeat (12) tick();
        checkOutput("pri_active_done", {28'b0, active}, 32'h0);

        // Handshake: read/write only when both FIFO flags are high.
        for (int k = 0; k < 8; k++) begin
            audio_in_available = hs_tbl[k][1];
            audio_out_allowed  = hs_tbl[k][0];
            #1;
            checkOutput($sformatf("hs_read_%0d", k),  {31'b0, read_audio_in},
                        {31'b0, (hs_tbl[k] == 2'b11)});
            checkOutput($sformatf("hs_write_%0d", k), {31'b0, write_audio_out},
                        {31'b0, (hs_tbl[k] == 2'b11)});
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
